// File: rtl/can_pkg.sv
// can_pkg: shared CAN types and constants for the frame-receive blocks
package can_pkg;
  localparam int CTRL_FIELD_BITS = 6;
  localparam int CAN_MAX_DATA_BYTES = 8;
  localparam logic DOMINANT = 1'b0;
  localparam logic RECESSIVE = 1'b1;
  typedef enum logic [1:0] {IDLE, RECEIVE, COMPLETE} ctrl_rx_state_t;
endpackage

// File: rtl/can_dlc_decode.sv
// can_dlc_decode: clamps a raw 4-bit DLC to the number of data bytes carried
module can_dlc_decode #(
  parameter int MAX_BYTES = 8
) (
  input  logic [3:0] dlc,
  output logic [3:0] data_bytes
);
  assign data_bytes = dlc > 4'(MAX_BYTES) ? 4'(MAX_BYTES) : dlc;
endmodule

// File: rtl/control_field_rx.sv
// control_field_rx: deserialises IDE, r0 and DLC after the RTR bit; CTRL_RX_R0_CHECK_EN adds r0_error
module control_field_rx
  import can_pkg::*;
#(
  parameter int CTRL_BITS = CTRL_FIELD_BITS,
  parameter int MAX_BYTES = CAN_MAX_DATA_BYTES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       sample_point,
  input  logic       stuff_bit_detected,
  input  logic       rx_bit,
  input  logic       rtr_complete,
  output logic       ide,
  output logic       r0,
  output logic [3:0] dlc,
  output logic [3:0] data_bytes,
  output logic [2:0] bit_counter,
  output logic       ide_error,
`ifdef CTRL_RX_R0_CHECK_EN
  output logic       r0_error,
`endif
  output logic       control_complete
);
  ctrl_rx_state_t state, state_next;
  logic [CTRL_BITS-2:0] shift;
  logic [CTRL_BITS-1:0] word;
  logic [3:0] word_bytes;
  logic valid, last;
  assign valid = state == RECEIVE && sample_point && !stuff_bit_detected;
  assign last = valid && bit_counter == 3'(CTRL_BITS - 1);
  // word is the complete field as it stands once the current bit is taken in
  assign word = {shift, rx_bit};
  can_dlc_decode #(.MAX_BYTES(MAX_BYTES)) u_dlc_decode (
    .dlc(word[3:0]),
    .data_bytes(word_bytes)
  );
  always_comb begin
    state_next = IDLE;
    control_complete = state == COMPLETE;
    state_next = state == IDLE ? (rtr_complete ? RECEIVE : IDLE) :
                 state == RECEIVE ? (last ? COMPLETE : RECEIVE) : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      state <= IDLE;
      shift <= '0;
      bit_counter <= '0;
      ide <= 1'b1;
      r0 <= 1'b0;
      dlc <= '0;
      data_bytes <= '0;
      ide_error <= 1'b0;
`ifdef CTRL_RX_R0_CHECK_EN
      r0_error <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (state == IDLE && rtr_complete) begin
        shift <= '0;
        bit_counter <= '0;
      end else if (valid) begin
        shift <= word[CTRL_BITS-2:0];
        bit_counter <= last ? 3'd0 : bit_counter + 3'd1;
      end
      if (last) begin
        ide <= word[CTRL_BITS-1];
        r0 <= word[CTRL_BITS-2];
        dlc <= word[3:0];
        data_bytes <= word_bytes;
        ide_error <= word[CTRL_BITS-1] == RECESSIVE;
`ifdef CTRL_RX_R0_CHECK_EN
        r0_error <= word[CTRL_BITS-2] == RECESSIVE;
`endif
      end
    end
  end
endmodule

// File: tb/tb_control_field_rx.sv
// tb_control_field_rx: table-driven frames with a scoreboard of expected latched fields
module tb_control_field_rx;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b1, sample_point = 1'b0;
  logic stuff_bit_detected = 1'b0, rx_bit = 1'b0, rtr_complete = 1'b0;
  logic ide, r0, ide_error, control_complete;
  logic [3:0] dlc, data_bytes;
  logic [2:0] bit_counter;
`ifdef CTRL_RX_R0_CHECK_EN
  logic r0_error;
`endif
  control_field_rx dut (
    .clock(clock), .reset(reset), .enable(enable), .sample_point(sample_point),
    .stuff_bit_detected(stuff_bit_detected), .rx_bit(rx_bit), .rtr_complete(rtr_complete),
    .ide(ide), .r0(r0), .dlc(dlc), .data_bytes(data_bytes), .bit_counter(bit_counter),
    .ide_error(ide_error),
`ifdef CTRL_RX_R0_CHECK_EN
    .r0_error(r0_error),
`endif
    .control_complete(control_complete)
  );
  always #5 clock = ~clock;
  typedef struct packed {logic ide; logic r0; logic [3:0] dlc; logic [3:0] db; logic ide_err;} exp_t;
  typedef struct {logic [5:0] bits; logic [7:0] stuff; exp_t e;} vec_t;
  localparam exp_t RST_EXP = 11'b1_0_0000_0000_0;
  exp_t sb[$];
  exp_t last = RST_EXP;
  vec_t v[8];
  int checks = 0, passes = 0, pulses = 0, frames = 0;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  task automatic check_reset();
    chk("rst_ide", ide, 1);
    chk("rst_r0", r0, 0);
    chk("rst_dlc", dlc, 0);
    chk("rst_bytes", data_bytes, 0);
    chk("rst_ide_err", ide_error, 0);
    chk("rst_pulse", control_complete, 0);
    chk("rst_cnt", bit_counter, 0);
`ifdef CTRL_RX_R0_CHECK_EN
    chk("rst_r0_err", r0_error, 0);
`endif
  endtask
  always @(negedge clock) begin
    if (control_complete) begin
      exp_t e;
      pulses++;
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ide", ide, e.ide);
        chk("r0", r0, e.r0);
        chk("dlc", dlc, e.dlc);
        chk("data_bytes", data_bytes, e.db);
        chk("ide_error", ide_error, e.ide_err);
`ifdef CTRL_RX_R0_CHECK_EN
        chk("r0_error", r0_error, e.r0);
`endif
      end
    end
  end
  // abort: 0 = full frame, 1 = reset after 3 valid bits, 2 = enable low after 3 valid bits
  task automatic frame(input logic [5:0] bits, input logic [7:0] stuff, input exp_t e,
                       input bit coinc, input int abort);
    int n = 0;
    int s = 0;
    logic st;
    if (abort == 0) begin
      sb.push_back(e);
      frames++;
    end
    rtr_complete = 1'b1;
    sample_point = coinc;
    rx_bit = 1'b1;
    @(negedge clock);
    rtr_complete = 1'b0;
    sample_point = 1'b0;
    chk("arm_cnt", bit_counter, 0);
    chk("hold_dlc", dlc, last.dlc);
    chk("hold_ide", ide, last.ide);
    while (n < 6) begin
      if (abort != 0 && n == 3) break;
      st = s < 8 && stuff[s];
      sample_point = 1'b1;
      stuff_bit_detected = st;
      rx_bit = st ? ~bits[5-n] : bits[5-n];
      if (!st) n++;
      s++;
      @(negedge clock);
      sample_point = 1'b0;
      stuff_bit_detected = 1'b0;
      if (n == 6) begin
        chk("pulse", control_complete, 1);
        chk("cnt_wrap", bit_counter, 0);
      end else begin
        chk("cnt", bit_counter, 8'(n));
        chk("no_pulse", control_complete, 0);
        @(negedge clock);
      end
    end
    if (abort != 0) begin
      if (abort == 1) reset = 1'b1;
      else enable = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      enable = 1'b1;
      check_reset();
      last = RST_EXP;
      repeat (4) @(negedge clock);
    end else begin
      @(negedge clock);
      chk("pulse_end", control_complete, 0);
      last = e;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    v[0] = '{6'b000101, 8'h00, {1'b0, 1'b0, 4'd5, 4'd5, 1'b0}};
    v[1] = '{6'b001111, 8'h00, {1'b0, 1'b0, 4'd15, 4'd8, 1'b0}};
    v[2] = '{6'b000101, 8'b0001_0100, {1'b0, 1'b0, 4'd5, 4'd5, 1'b0}};
    v[3] = '{6'b100010, 8'h00, {1'b1, 1'b0, 4'd2, 4'd2, 1'b1}};
    v[4] = '{6'b001000, 8'h00, {1'b0, 1'b0, 4'd8, 4'd8, 1'b0}};
    v[5] = '{6'b001001, 8'h01, {1'b0, 1'b0, 4'd9, 4'd8, 1'b0}};
    v[6] = '{6'b010001, 8'h00, {1'b0, 1'b1, 4'd1, 4'd1, 1'b0}};
    v[7] = '{6'b110011, 8'b0010_0000, {1'b1, 1'b1, 4'd3, 4'd3, 1'b1}};
    repeat (2) @(negedge clock);
    check_reset();
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 8; i++) frame(v[i].bits, v[i].stuff, v[i].e, 1'b0, 0);
    frame(6'b000101, 8'h00, v[0].e, 1'b0, 1);
    frame(v[4].bits, 8'h00, v[4].e, 1'b0, 0);
    frame(6'b001111, 8'h00, v[1].e, 1'b0, 2);
    frame(v[0].bits, 8'h00, v[0].e, 1'b1, 0);
    frame(v[3].bits, 8'h00, v[3].e, 1'b1, 0);
    repeat (3) @(negedge clock);
    chk("pulse_count", 8'(pulses), 8'(frames));
    chk("sb_drained", 8'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
